// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and iteration count.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    // Divide ops have op[1] set.
    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

    // Signed ops (MULT, DIV) have op[0] set.
    function automatic logic op_is_signed(input op_e o);
        return o[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the register-file side and the muldiv unit.
interface muldiv_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, busA, busB,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, busA, busB,
        output busy, done, divzero, hi, lo
    );

endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: dout = neg ? -din : din.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Invert and add one when negation is requested.
    always_comb begin
        dout = din;
        if (neg) begin
            dout = (~din) + WIDTH'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle over 32 cycles, result into hi/lo.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic              sign_a;
    logic              sign_b;
    logic              b_zero;
    logic [31:0]       opnd;      // multiplicand or divisor magnitude
    logic [31:0]       acc_hi;    // partial product high / partial remainder
    logic [31:0]       acc_lo;    // multiplier bits / dividend-quotient bits
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              busy_q;
    logic              done_q;
    logic              divzero_q;

    // Operand capture
    op_e               op_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;

    // Iteration step
    logic [32:0]       mul_sum;
    logic [32:0]       div_shift;
    logic              div_ge;
    logic [31:0]       step_hi;
    logic [31:0]       step_lo;

    // Result fix-up
    logic              prod_neg;
    logic              quo_neg;
    logic              rem_neg;
    logic [63:0]       prod_fix;
    logic [31:0]       quo_fix;
    logic [31:0]       rem_fix;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    // Decode the incoming request and its operand signs.
    always_comb begin
        op_in    = op_e'(bus.op);
        neg_a_in = op_is_signed(op_in) & bus.busA[31];
        neg_b_in = op_is_signed(op_in) & bus.busB[31];
    end

    muldiv_negate #(.WIDTH(32)) u_neg_a (
        .din  (bus.busA),
        .neg  (neg_a_in),
        .dout (mag_a)
    );

    muldiv_negate #(.WIDTH(32)) u_neg_b (
        .din  (bus.busB),
        .neg  (neg_b_in),
        .dout (mag_b)
    );

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (op_is_div(op_q)) begin
            // Remainder stays below the divisor, so the 32-bit difference
            // is exact whenever the subtract is taken.
            step_hi = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
            step_lo = {acc_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // Sign fix-up controls for the final step's result.
    always_comb begin
        prod_neg = (op_q == OP_MULT) & (sign_a ^ sign_b);
        quo_neg  = (op_q == OP_DIV)  & (sign_a ^ sign_b);
        rem_neg  = (op_q == OP_DIV)  & sign_a;
    end

    muldiv_negate #(.WIDTH(64)) u_neg_prod (
        .din  ({step_hi, step_lo}),
        .neg  (prod_neg),
        .dout (prod_fix)
    );

    muldiv_negate #(.WIDTH(32)) u_neg_quo (
        .din  (step_lo),
        .neg  (quo_neg),
        .dout (quo_fix)
    );

    muldiv_negate #(.WIDTH(32)) u_neg_rem (
        .din  (step_hi),
        .neg  (rem_neg),
        .dout (rem_fix)
    );

    // Select the value written to hi/lo on the final RUN edge.
    always_comb begin
        if (op_is_div(op_q)) begin
            // With a zero divisor the restoring loop leaves |A| as remainder,
            // and the remainder sign fix-up turns that back into busA.
            res_hi = rem_fix;
            res_lo = b_zero ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= OP_MULTU;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        op_q   <= op_in;
                        sign_a <= neg_a_in;
                        sign_b <= neg_b_in;
                        b_zero <= op_is_div(op_in) & (bus.busB == '0);
                        opnd   <= op_is_div(op_in) ? mag_b : mag_a;
                        acc_hi <= '0;
                        acc_lo <= op_is_div(op_in) ? mag_a : mag_b;
                        cnt    <= CNT_W'(ITERATIONS - 1);
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == '0) begin
                        state     <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        divzero_q <= b_zero;
                        hi_q      <= res_hi;
                        lo_q      <= res_lo;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    divzero_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = divzero_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, reset and
// start-while-busy scenarios, then randomized ops against an arithmetic model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns {divzero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa;
        longint sb;
        longint q;
        longint m;
        sa = $signed(a);
        sb = $signed(b);
        if (o[1] && b == 32'd0) begin
            return {1'b1, a, 32'hFFFF_FFFF};
        end
        case (o)
            2'b00: r = {32'd0, a} * {32'd0, b};
            2'b01: r = sa * sb;
            2'b10: r = {a % b, a / b};
            default: begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
        endcase
        return {1'b0, r};
    endfunction

    // Issue one op from an idle cycle and check its whole lifetime.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, input string name);
        logic [64:0] e;
        int cyc;
        int bcnt;
        e = model(o, a, b);
        cyc = 0;
        bcnt = 0;
        bus.start = 1'b1;
        bus.op    = o;
        bus.busA  = a;
        bus.busB  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.busA  = $urandom;
        bus.busB  = $urandom;
        bus.op    = 2'($urandom);
        check({name, ".hi_hold_run"}, bus.hi, prev_hi);
        check({name, ".lo_hold_run"}, bus.lo, prev_lo);
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            if (noisy) bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({name, ".latency"}, 32'(cyc), 32'd32);
        check({name, ".busy_cycles"}, 32'(bcnt), 32'd32);
        check({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, ".hi"}, bus.hi, e[63:32]);
        check({name, ".lo"}, bus.lo, e[31:0]);
        check({name, ".divzero"}, 32'(bus.divzero), 32'(e[64]));
        prev_hi = e[63:32];
        prev_lo = e[31:0];
        @(posedge clk); #1;
        check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({name, ".divzero_clr"}, 32'(bus.divzero), 32'd0);
        check({name, ".hi_hold"}, bus.hi, prev_hi);
        check({name, ".lo_hold"}, bus.lo, prev_lo);
    endtask

    initial begin
        int cyc;
        int done_seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.busA  = '0;
        bus.busB  = '0;
        #12;
        check("rst.hi", bus.hi, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.divzero", 32'(bus.divzero), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         1'b0, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg");
        run_op(2'b10, 32'd100,       32'd7,         1'b0, "divu_100_7");
        run_op(2'b10, 32'h1234_5678, 32'd0,         1'b0, "divu_zero");
        run_op(2'b00, 32'd6,         32'd7,         1'b0, "after_divzero");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_minint");
        run_op(2'b11, 32'hFFFF_FFF0, 32'd0,         1'b0, "div_zero_neg");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, "mult_minint");

        // Second start mid-run must be ignored and not queued.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.busA  = 32'd3;
        bus.busB  = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        repeat (9) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.busA  = $urandom;
        bus.busB  = $urandom;
        @(posedge clk); #1;
        cyc++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("restart.latency", 32'(cyc), 32'd32);
        check("restart.hi", bus.hi, 32'd0);
        check("restart.lo", bus.lo, 32'd15);
        prev_hi = 32'd0;
        prev_lo = 32'd15;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("restart.no_queue", 32'(bus.busy), 32'd0);

        // Reset in the middle of a run discards the operation.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.busA  = 32'hFFFF_FFFF;
        bus.busB  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst.hi", bus.hi, 32'd0);
        check("midrst.lo", bus.lo, 32'd0);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("midrst.done_never", 32'(done_seen), 32'd0);
        check("midrst.hi_after", bus.hi, 32'd0);
        check("midrst.lo_after", bus.lo, 32'd0);
        prev_hi = '0;
        prev_lo = '0;
        run_op(2'b01, 32'd12345, 32'hFFFF_FF00, 1'b0, "first_after_rst");

        // Randomized ops, with a bias toward zero divisors and extreme operands.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
